// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 execute stage.
// Holds the ALU opcode, forward-select and mul/div FSM state encodings,
// plus small opcode-class helpers used by the top and the mul/div unit.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int RF_ADDR_WIDTH = 5;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_PASSB  = 5'd10,
        ALU_MUL    = 5'd16,
        ALU_MULH   = 5'd17,
        ALU_MULHSU = 5'd18,
        ALU_MULHU  = 5'd19,
        ALU_DIV    = 5'd20,
        ALU_DIVU   = 5'd21,
        ALU_REM    = 5'd22,
        ALU_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_e;

    // M-extension opcodes occupy 16..23.
    function automatic logic is_m_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // Divide/remainder opcodes occupy 20..23.
    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// magnitudes, with the sign fixed up from latched operand signs at the end.
// Divide-by-zero and signed overflow skip the iteration and finish at once.
// Only instantiated when RV_M_EXT_EN is defined.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier / dividend, becomes quotient
    logic [XLEN-1:0] b_q, b_d;       // |multiplicand| or |divisor|
    logic [4:0]      op_q, op_d;
    logic            neg_q, neg_d;         // negate product or quotient
    logic            neg_rem_q, neg_rem_d; // negate remainder

    logic            sgn_a_s, sgn_b_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s;
    logic            div_zero_s, div_ovf_s;
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_diff_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0] quo_fix_s, rem_fix_s;

    // Classify the incoming operation: operand signs, magnitudes, special divides.
    always_comb begin
        sgn_a_s = ((op_i == ALU_MULH) || (op_i == ALU_MULHSU) ||
                   (op_i == ALU_DIV)  || (op_i == ALU_REM)) && a_i[XLEN-1];
        sgn_b_s = ((op_i == ALU_MULH) || (op_i == ALU_DIV) ||
                   (op_i == ALU_REM)) && b_i[XLEN-1];
        if (sgn_a_s) begin
            abs_a_s = {XLEN{1'b0}} - a_i;
        end else begin
            abs_a_s = a_i;
        end
        if (sgn_b_s) begin
            abs_b_s = {XLEN{1'b0}} - b_i;
        end else begin
            abs_b_s = b_i;
        end
        div_zero_s = is_div_op(op_i) && (b_i == {XLEN{1'b0}});
        div_ovf_s  = ((op_i == ALU_DIV) || (op_i == ALU_REM)) &&
                     (a_i == MIN_NEG) && (b_i == {XLEN{1'b1}});
    end

    // One iteration step of each algorithm, computed from the current registers.
    always_comb begin
        if (lo_q[0]) begin
            mul_sum_s = {1'b0, hi_q} + {1'b0, b_q};
        end else begin
            mul_sum_s = {1'b0, hi_q};
        end
        div_shift_s = {hi_q, lo_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
    end

    // FSM next state, datapath next values and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    stall_o   = 1'b1;
                    op_d      = op_i;
                    cnt_d     = CNT_LOAD;
                    b_d       = abs_b_s;
                    hi_d      = {XLEN{1'b0}};
                    lo_d      = abs_a_s;
                    neg_d     = sgn_a_s ^ sgn_b_s;
                    neg_rem_d = sgn_a_s;
                    if (div_zero_s) begin
                        // quotient all ones, remainder is the raw dividend
                        lo_d      = {XLEN{1'b1}};
                        hi_d      = a_i;
                        neg_d     = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = MD_DONE;
                    end else if (div_ovf_s) begin
                        lo_d      = MIN_NEG;
                        hi_d      = {XLEN{1'b0}};
                        neg_d     = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = MD_DONE;
                    end else begin
                        state_d   = MD_BUSY;
                    end
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                if (flush_i) begin
                    state_d = MD_IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (is_div_op(op_q)) begin
                        if (!div_diff_s[XLEN]) begin
                            hi_d = div_diff_s[XLEN-1:0];
                        end else begin
                            hi_d = div_shift_s[XLEN-1:0];
                        end
                        lo_d = {lo_q[XLEN-2:0], ~div_diff_s[XLEN]};
                    end else begin
                        {hi_d, lo_d} = {mul_sum_s, lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = MD_DONE;
                    end else begin
                        state_d = MD_BUSY;
                    end
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
                done_o  = ~flush_i;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // Sign fix-up and selection of the architectural result.
    always_comb begin
        prod_s = {hi_q, lo_q};
        if (neg_q) begin
            prod_fix_s = {(2*XLEN){1'b0}} - prod_s;
            quo_fix_s  = {XLEN{1'b0}} - lo_q;
        end else begin
            prod_fix_s = prod_s;
            quo_fix_s  = lo_q;
        end
        if (neg_rem_q) begin
            rem_fix_s = {XLEN{1'b0}} - hi_q;
        end else begin
            rem_fix_s = hi_q;
        end
        case (op_q)
            ALU_MUL:                          result_o = prod_fix_s[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  result_o = prod_fix_s[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                result_o = quo_fix_s;
            ALU_REM, ALU_REMU:                result_o = rem_fix_s;
            default:                          result_o = {XLEN{1'b0}};
        endcase
    end

    // State and datapath registers; reset returns to IDLE with cleared datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            cnt_q     <= {CW{1'b0}};
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            b_q       <= {XLEN{1'b0}};
            op_q      <= 5'd0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/riscv_ex_stage.sv
// Execute stage of the 5-stage RV32 pipeline.
// Resolves forwarded operands, runs the single-cycle ALU and muxes in the
// iterative mul/div result. Build macro RV_M_EXT_EN enables the M extension;
// without it M opcodes are reported illegal and the stage never stalls.
module riscv_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_id2ex_ff,
    input  logic [4:0]      alu_op_id2ex_ff,
    input  logic            src_a_pc_id2ex_ff,
    input  logic            src_b_imm_id2ex_ff,
    input  logic [XLEN-1:0] pc_id2ex_ff,
    input  logic [XLEN-1:0] imm_id2ex_ff,
    input  logic [XLEN-1:0] rs1_data_id2ex_ff,
    input  logic [XLEN-1:0] rs2_data_id2ex_ff,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] alu_result_ex2mem_ff,
    input  logic [XLEN-1:0] wb_data_mem2wb,
    input  logic            flush_ex,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_valid,
    output logic            ex_stall,
    output logic            ex_illegal
);

    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a_val_s, fwd_b_val_s;
    logic [XLEN-1:0] op_a_s, op_b_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            alu_illegal_s;
    logic            m_supported_s;
    logic            md_stall_s, md_done_s;
    logic [XLEN-1:0] md_result_s;

    // Operand A forward mux; the reserved select falls back to register data.
    always_comb begin
        case (fwd_a)
            FWD_WB:  fwd_a_val_s = wb_data_mem2wb;
            FWD_MEM: fwd_a_val_s = alu_result_ex2mem_ff;
            default: fwd_a_val_s = rs1_data_id2ex_ff;
        endcase
    end

    // Operand B forward mux; the reserved select falls back to register data.
    always_comb begin
        case (fwd_b)
            FWD_WB:  fwd_b_val_s = wb_data_mem2wb;
            FWD_MEM: fwd_b_val_s = alu_result_ex2mem_ff;
            default: fwd_b_val_s = rs2_data_id2ex_ff;
        endcase
    end

    assign op_a_s        = src_a_pc_id2ex_ff  ? pc_id2ex_ff  : fwd_a_val_s;
    assign op_b_s        = src_b_imm_id2ex_ff ? imm_id2ex_ff : fwd_b_val_s;
    assign shamt_s       = op_b_s[SHW-1:0];
    assign ex_store_data = fwd_b_val_s;

    // Single-cycle ALU; anything it does not implement is flagged illegal.
    always_comb begin
        alu_res_s     = {XLEN{1'b0}};
        alu_illegal_s = 1'b0;
        case (alu_op_id2ex_ff)
            ALU_ADD:   alu_res_s = op_a_s + op_b_s;
            ALU_SUB:   alu_res_s = op_a_s - op_b_s;
            ALU_SLL:   alu_res_s = op_a_s << shamt_s;
            ALU_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
            ALU_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
            ALU_XOR:   alu_res_s = op_a_s ^ op_b_s;
            ALU_SRL:   alu_res_s = op_a_s >> shamt_s;
            ALU_SRA:   alu_res_s = $signed(op_a_s) >>> shamt_s;
            ALU_OR:    alu_res_s = op_a_s | op_b_s;
            ALU_AND:   alu_res_s = op_a_s & op_b_s;
            ALU_PASSB: alu_res_s = op_b_s;
            default:   alu_illegal_s = 1'b1;
        endcase
    end

`ifdef RV_M_EXT_EN
    logic is_m_s;
    logic md_start_s;

    assign is_m_s        = is_m_op(alu_op_id2ex_ff);
    assign m_supported_s = is_m_s;
    assign md_start_s    = valid_id2ex_ff & ~flush_ex & is_m_s;

    riscv_muldiv #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start_s),
        .flush_i  (flush_ex),
        .op_i     (alu_op_id2ex_ff),
        .a_i      (op_a_s),
        .b_i      (op_b_s),
        .stall_o  (md_stall_s),
        .done_o   (md_done_s),
        .result_o (md_result_s)
    );
`else
    logic unused_clk_s;

    assign unused_clk_s  = clk;
    assign m_supported_s = 1'b0;
    assign md_stall_s    = 1'b0;
    assign md_done_s     = 1'b0;
    assign md_result_s   = {XLEN{1'b0}};
`endif

    // Stage outputs: reset silences everything, a finished M op wins, then stall,
    // then the single-cycle path.
    always_comb begin
        ex_result  = {XLEN{1'b0}};
        ex_valid   = 1'b0;
        ex_stall   = 1'b0;
        ex_illegal = 1'b0;
        if (rst) begin
            ex_valid = 1'b0;
        end else if (md_done_s) begin
            ex_result = md_result_s;
            ex_valid  = 1'b1;
        end else if (md_stall_s) begin
            ex_stall = 1'b1;
        end else if (m_supported_s) begin
            // M op that is flushed or not valid: nothing leaves EX
            ex_valid = 1'b0;
        end else if (alu_illegal_s) begin
            ex_illegal = 1'b1;
            ex_valid   = valid_id2ex_ff & ~flush_ex;
        end else begin
            ex_result = alu_res_s;
            ex_valid  = valid_id2ex_ff & ~flush_ex;
        end
    end

endmodule
